// File: rtl/uart_pkg.sv
// uart_pkg: state codes and framing constants shared by the UART transmitter and receiver.
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    START = 3'b001,
    DATA  = 3'b010,
    STOP  = 3'b011
  } state_e;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  localparam int DATA_BITS = 8;
  localparam int CLKS_PER_BIT = 16;
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready byte handshake into the UART transmitter.
interface uart_tx_if;
  import uart_pkg::*;
  logic [DATA_BITS-1:0] data_in;
  logic in_valid;
  logic in_ready;
  modport master(output data_in, output in_valid, input in_ready);
  modport slave(input data_in, input in_valid, output in_ready);
endinterface

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: modulo-CLKS_PER_BIT clock counter with a strobe on the last count of each bit.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt_q, cnt_d;
  assign bit_end = cnt_q == W'(CLKS_PER_BIT - 1);
  always_comb cnt_d = (clr || bit_end) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk) cnt_q <= !rst ? '0 : cnt_d;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter fed by a valid/ready byte handshake.
// Define UART_TX_BUF_EN to add a one-entry holding register for gapless back-to-back frames.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
  parameter int DATA_BITS = uart_pkg::DATA_BITS
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave s,
  output logic     tx,
  output logic     busy,
  output logic     tx_done
);
  localparam int BW = $clog2(DATA_BITS);
  state_e state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, load_data;
  logic [BW-1:0] bit_q, bit_d;
  logic tx_q, tx_d, rdy_q, rdy_d, accept, load, bit_end;
`ifdef UART_TX_BUF_EN
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic full_q, full_d, direct;
`endif
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(state_d != state_q),
    .bit_end(bit_end)
  );
  assign accept = s.in_valid & rdy_q;
  assign s.in_ready = rdy_q;
  assign tx = tx_q;
  assign busy = state_q != IDLE;
  assign tx_done = (state_q == STOP) & bit_end;
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d = bit_q;
    load = 1'b0;
    load_data = s.data_in;
    unique case (state_q)
      IDLE: load = accept;
      START: state_d = bit_end ? DATA : START;
      DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        bit_d = bit_q + 1'b1;
        state_d = (bit_q == BW'(DATA_BITS - 1)) ? STOP : DATA;
      end
      STOP: if (bit_end) begin
`ifdef UART_TX_BUF_EN
        load = full_q | accept;
        load_data = full_q ? hold_q : s.data_in;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = START;
      shift_d = load_data;
      bit_d = '0;
    end
    // tx is registered, so it is derived from the state being entered
    tx_d = state_d == START ? START_BIT : state_d == DATA ? shift_d[0] : STOP_BIT;
`ifdef UART_TX_BUF_EN
    direct = load & ~full_q;
    full_d = (full_q & ~load) | (accept & ~direct);
    hold_d = (accept & ~direct) ? s.data_in : hold_q;
    rdy_d = ~full_d;
`else
    rdy_d = state_d == IDLE;
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q <= '0;
      tx_q <= STOP_BIT;
      rdy_q <= 1'b1;
`ifdef UART_TX_BUF_EN
      hold_q <= '0;
      full_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q <= bit_d;
      tx_q <= tx_d;
      rdy_q <= rdy_d;
`ifdef UART_TX_BUF_EN
      hold_q <= hold_d;
      full_q <= full_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx (honours UART_TX_BUF_EN).
module tb_uart_tx;
  localparam int CPB = 16;
  localparam int FL = 10 * CPB;
  localparam int TMAX = 2048;
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx, busy, tx_done;
  int n_chk = 0;
  int n_fail = 0;
  logic tr_tx[TMAX];
  logic tr_busy[TMAX];
  logic tr_done[TMAX];
  logic tr_rdy[TMAX];
  int acc_q[$];
  logic [7:0] send_q[$];
  uart_tx_if u_if ();
  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .s(u_if.slave),
    .tx(tx),
    .busy(busy),
    .tx_done(tx_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  // Samples outputs once per cycle (index c = #1 after edge c) while draining send_q
  // through the handshake; acc_q records the cycle whose closing edge accepted a byte.
  task automatic run(input int n, input int rst_at);
    logic acc;
    acc_q.delete();
    for (int c = 0; c < n; c++) begin
      tr_tx[c] = tx;
      tr_busy[c] = busy;
      tr_done[c] = tx_done;
      tr_rdy[c] = u_if.in_ready;
      u_if.in_valid = send_q.size() > 0;
      u_if.data_in = send_q.size() > 0 ? send_q[0] : 8'h00;
      acc = u_if.in_valid & u_if.in_ready;
      if (c == rst_at) rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      if (acc) begin
        acc_q.push_back(c);
        void'(send_q.pop_front());
      end
    end
    u_if.in_valid = 1'b0;
  endtask
  task automatic check_frame(input string nm, input int s, input logic [9:0] fr);
    int errs, dn;
    for (int b = 0; b < 10; b++) begin
      errs = 0;
      for (int k = 0; k < CPB; k++) if (tr_tx[s + 1 + b * CPB + k] !== fr[b]) errs++;
      chk($sformatf("%s bit%0d wrong-cycles", nm, b), errs, 0);
    end
    dn = 0;
    for (int k = 1; k <= FL; k++) if (tr_done[s + k] === 1'b1) dn++;
    chk({nm, " tx_done count"}, dn, 1);
    chk({nm, " tx_done last stop cycle"}, tr_done[s + FL], 1'b1);
    chk({nm, " busy during frame"}, tr_busy[s + 1], 1'b1);
  endtask
  initial begin
    vec_t vecs[5];
    logic [7:0] got[$];
    int s, errs, fmt_err, c;
    logic [7:0] b;
    vecs[0] = '{8'hA5, 10'b1_10100101_0};
    vecs[1] = '{8'h3C, 10'b1_00111100_0};
    vecs[2] = '{8'h81, 10'b1_10000001_0};
    vecs[3] = '{8'h00, 10'b1_00000000_0};
    vecs[4] = '{8'hFF, 10'b1_11111111_0};
    u_if.in_valid = 1'b0;
    u_if.data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset tx", tx, 1'b1);
    chk("reset in_ready", u_if.in_ready, 1'b1);
    chk("reset busy", busy, 1'b0);
    chk("reset tx_done", tx_done, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      send_q.push_back(vecs[i].data);
      run(FL + 4, -1);
      chk($sformatf("vec%0d accepted", i), acc_q.size(), 1);
      chk($sformatf("vec%0d accept cycle", i), acc_q.size() > 0 ? acc_q[0] : -1, 0);
      chk($sformatf("vec%0d idle before", i), tr_tx[0], 1'b1);
      check_frame($sformatf("vec%0d", i), 0, vecs[i].frame);
      chk($sformatf("vec%0d busy after", i), tr_busy[FL + 1], 1'b0);
      chk($sformatf("vec%0d ready after", i), tr_rdy[FL + 1], 1'b1);
    end
    send_q.push_back(8'h00);
    send_q.push_back(8'hFF);
    run(2 * FL + 8, -1);
    chk("b2b accepts", acc_q.size(), 2);
    check_frame("b2b first", 0, 10'b1_00000000_0);
`ifdef UART_TX_BUF_EN
    chk("b2b second accept", acc_q.size() > 1 ? acc_q[1] : -1, 1);
    chk("b2b ready cycle1", tr_rdy[1], 1'b1);
    chk("b2b ready full", tr_rdy[2], 1'b0);
    chk("b2b ready at move", tr_rdy[FL], 1'b0);
    chk("b2b ready after move", tr_rdy[FL + 1], 1'b1);
    check_frame("b2b second", FL, 10'b1_11111111_0);
`else
    chk("b2b second accept", acc_q.size() > 1 ? acc_q[1] : -1, FL + 1);
    chk("b2b gap tx", tr_tx[FL + 1], 1'b1);
    chk("b2b gap busy", tr_busy[FL + 1], 1'b0);
    chk("b2b gap ready", tr_rdy[FL + 1], 1'b1);
    check_frame("b2b second", FL + 1, 10'b1_11111111_0);
`endif
    send_q.push_back(8'h3C);
    run(300, 70);
    chk("rst-mid busy before", tr_busy[70], 1'b1);
    chk("rst-mid tx", tr_tx[71], 1'b1);
    chk("rst-mid busy", tr_busy[71], 1'b0);
    chk("rst-mid ready", tr_rdy[71], 1'b1);
    errs = 0;
    for (int k = 0; k < 300; k++) if (tr_done[k] !== 1'b0) errs++;
    chk("rst-mid tx_done pulses", errs, 0);
    errs = 0;
    for (int k = 71; k < 300; k++) if (tr_tx[k] !== 1'b1) errs++;
    chk("rst-mid tx idle after", errs, 0);
    run(500, -1);
    errs = 0;
    for (int k = 0; k < 500; k++) if (tr_tx[k] !== 1'b1) errs++;
    chk("idle tx low cycles", errs, 0);
    errs = 0;
    for (int k = 0; k < 500; k++) if (tr_busy[k] !== 1'b0) errs++;
    chk("idle busy cycles", errs, 0);
    errs = 0;
    for (int k = 0; k < 500; k++) if (tr_done[k] !== 1'b0) errs++;
    chk("idle tx_done pulses", errs, 0);
    foreach (vecs[i]) if (i == 0) send_q.push_back(8'h00);
    send_q.push_back(8'h55);
    send_q.push_back(8'hAA);
    send_q.push_back(8'hFF);
    send_q.push_back(8'h81);
    run(5 * (FL + 1) + 20, -1);
    // mid-bit sampling receiver: finds each start bit, reads 8 data bits and the stop bit
    fmt_err = 0;
    c = 0;
    while (c + 10 * CPB < 5 * (FL + 1) + 20) begin
      if (tr_tx[c] === 1'b0) begin
        s = c + CPB / 2;
        for (int i = 0; i < 8; i++) b[i] = tr_tx[s + (i + 1) * CPB];
        if (tr_tx[s + 9 * CPB] !== 1'b1 || tr_tx[s] !== 1'b0) fmt_err++;
        got.push_back(b);
        c = s + 9 * CPB + 1;
      end else c++;
    end
    chk("loop bytes received", got.size(), 5);
    chk("loop format_err", fmt_err, 0);
    chk("loop byte0", got.size() > 0 ? got[0] : 8'hxx, 8'h00);
    chk("loop byte1", got.size() > 1 ? got[1] : 8'hxx, 8'h55);
    chk("loop byte2", got.size() > 2 ? got[2] : 8'hxx, 8'hAA);
    chk("loop byte3", got.size() > 3 ? got[3] : 8'hxx, 8'hFF);
    chk("loop byte4", got.size() > 4 ? got[4] : 8'hxx, 8'h81);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
